// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared stall encodings, zero constants and a popcount helper
package pipe_stage_reg_pkg;
    localparam int          STALL_W   = 6;
    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;
    localparam logic        ZERO_BIT  = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction
endpackage

// File: rtl/pipe_stage_reg_lane_wr_sanitize.sv
// lane_wr_sanitize: squash r0 / invalid-lane writes and resolve same-destination conflicts (highest lane wins)
//   i_valid         : per-lane valid
//   i_rn            : per-lane destination register, lane k at [k*RN_W +: RN_W]
//   i_write_regfile : per-lane raw write enable
//   o_write_regfile : per-lane sanitised write enable
module lane_wr_sanitize #(
    parameter int LANES = 2,
    parameter int RN_W  = 5
) (
    input  logic [LANES-1:0]      i_valid,
    input  logic [LANES*RN_W-1:0] i_rn,
    input  logic [LANES-1:0]      i_write_regfile,
    output logic [LANES-1:0]      o_write_regfile
);
    logic [LANES-1:0] w_base;

    always_comb begin
        w_base          = '0;
        o_write_regfile = '0;
        for (int k = 0; k < LANES; k++)
            w_base[k] = i_valid[k] & i_write_regfile[k] & (i_rn[k*RN_W +: RN_W] != '0);
        // A lower lane loses its write if any later lane still writes the same register.
        for (int j = 0; j < LANES; j++) begin
            o_write_regfile[j] = w_base[j];
            for (int k = j + 1; k < LANES; k++)
                if (w_base[k] && i_rn[k*RN_W +: RN_W] == i_rn[j*RN_W +: RN_W])
                    o_write_regfile[j] = 1'b0;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-lane pipeline register with hold/bubble/flush control and write sanitising
//   clk, reset (sync, active-high), stall[5:0] (1 = stop), flush
//   i_valid/i_d1/i_d2/i_rn/i_write_regfile/i_mem_to_regfile : incoming bundle, lane k in slice k
//   o_* : registered bundle (write enable sanitised)
//   o_cnt_retired/o_cnt_bubble/o_cnt_hold : performance counters, live only with PIPE_PERF_CNT_EN
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int RN_W   = 5,
    parameter int STAGE  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        i_valid,
    input  logic [LANES*DATA_W-1:0] i_d1,
    input  logic [LANES*DATA_W-1:0] i_d2,
    input  logic [LANES*RN_W-1:0]   i_rn,
    input  logic [LANES-1:0]        i_write_regfile,
    input  logic [LANES-1:0]        i_mem_to_regfile,
    output logic [LANES-1:0]        o_valid,
    output logic [LANES*DATA_W-1:0] o_d1,
    output logic [LANES*DATA_W-1:0] o_d2,
    output logic [LANES*RN_W-1:0]   o_rn,
    output logic [LANES-1:0]        o_write_regfile,
    output logic [LANES-1:0]        o_mem_to_regfile,
    output logic [31:0]             o_cnt_retired,
    output logic [31:0]             o_cnt_bubble,
    output logic [31:0]             o_cnt_hold
);
    logic                    w_bubble, w_hold, w_adv;
    logic [LANES-1:0]        w_we;
    logic [LANES-1:0]        r_valid, r_we, r_m2r;
    logic [LANES*DATA_W-1:0] r_d1, r_d2;
    logic [LANES*RN_W-1:0]   r_rn;

    assign w_adv    = stall[STAGE] == NO_STOP;
    assign w_bubble = stall[STAGE] == STOP && stall[STAGE+1] == NO_STOP;
    assign w_hold   = stall[STAGE] == STOP && stall[STAGE+1] == STOP;

    lane_wr_sanitize #(.LANES(LANES), .RN_W(RN_W)) u_san (
        .i_valid         (i_valid),
        .i_rn            (i_rn),
        .i_write_regfile (i_write_regfile),
        .o_write_regfile (w_we)
    );

    // Hold is the implicit "no assignment" path.
    always_ff @(posedge clk) begin
        if (reset || flush || w_bubble) begin
            r_valid <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_rn    <= '0;
            r_we    <= '0;
            r_m2r   <= '0;
        end else if (w_adv) begin
            r_valid <= i_valid;
            r_d1    <= i_d1;
            r_d2    <= i_d2;
            r_rn    <= i_rn;
            r_we    <= w_we;
            r_m2r   <= i_mem_to_regfile;
        end
    end

    assign o_valid          = r_valid;
    assign o_d1             = r_d1;
    assign o_d2             = r_d2;
    assign o_rn             = r_rn;
    assign o_write_regfile  = r_we;
    assign o_mem_to_regfile = r_m2r;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_cnt_retired, r_cnt_bubble, r_cnt_hold;
    logic [3:0]  w_valid4;

    assign w_valid4 = 4'(i_valid);

    // Retired counts every valid lane, including those whose write was squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_retired <= ZERO_WORD;
            r_cnt_bubble  <= ZERO_WORD;
            r_cnt_hold    <= ZERO_WORD;
        end else if (!flush) begin
            if (w_adv)    r_cnt_retired <= r_cnt_retired + {29'b0, popcount4(w_valid4)};
            if (w_bubble) r_cnt_bubble  <= r_cnt_bubble + 32'd1;
            if (w_hold)   r_cnt_hold    <= r_cnt_hold + 32'd1;
        end
    end

    assign o_cnt_retired = r_cnt_retired;
    assign o_cnt_bubble  = r_cnt_bubble;
    assign o_cnt_hold    = r_cnt_hold;
`else
    assign o_cnt_retired = ZERO_WORD;
    assign o_cnt_bubble  = ZERO_WORD;
    assign o_cnt_hold    = ZERO_WORD;
`endif
endmodule
